avalon_burst_ram_slave: RTL and testbench

- Avalon-MM burst responder that terminates the core's 32-bit bus master.
- Backs a single-port, word-addressed on-chip RAM.
- Serves single-word and line (16-beat) reads and writes, using the same address/burstcount/waitrequest/readdatavalid signalling the master drives.
- Sits on the FPGA fabric bus as boot/scratch memory for the CPU.

---
 rtl/avalon_burst_ram_slave_if.sv | 23 ++
 rtl/avalon_burst_ram_slave.sv | 119 +++++++++++
 tb/tb_avalon_burst_ram_slave.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_burst_ram_slave_if.sv
// Avalon-MM burst bus between the core's 32-bit master and the RAM responder.
// Clock and reset stay outside so the interface carries only bus signals.
interface avalon_burst_ram_slave_if;
    logic [29:0] s_address;
    logic [4:0]  s_burstcount;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;

    modport slave (
        input  s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid
    );

    modport master (
        output s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );
endinterface

// File: rtl/avalon_burst_ram_slave.sv
// Avalon-MM burst responder backed by a single-port word-addressed RAM.
// Serves single and multi-beat reads/writes; read data is registered (2-cycle latency).
module avalon_burst_ram_slave #(
    parameter int MEM_AW    = 12,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    avalon_burst_ram_slave_if.slave  s
);
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_BURST,
        ST_RD_DRAIN
    } state_t;

    state_t            r_state, w_state_next;
    logic [MEM_AW-1:0] r_addr, w_addr_next, w_mem_addr;
    logic [4:0]        r_cnt, w_cnt_next, w_cmd_cnt;
    logic              r_rst_d;
    logic              r_rdvalid;
    logic [31:0]       r_rdata;
    logic              w_accept, w_mem_we, w_issue;
    logic              w_unused_addr;
    logic [31:0]       r_mem [DEPTH];

    assign w_unused_addr = ^s.s_address[29:MEM_AW];

    // Hold off the master for one extra cycle after reset releases.
    assign s.s_waitrequest   = rst | r_rst_d;
    assign s.s_readdata      = r_rdata;
    assign s.s_readdatavalid = r_rdvalid;

    assign w_accept  = (r_state == ST_IDLE) && !s.s_waitrequest;
    assign w_cmd_cnt = (s.s_burstcount == 5'd0) ? 5'd1 : s.s_burstcount;

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_issue      = 1'b0;
        w_mem_addr   = r_addr;
        case (r_state)
            ST_IDLE: begin
                w_mem_addr = s.s_address[MEM_AW-1:0];
                if (w_accept && s.s_write) begin
                    // Beat 0 of a write lands in the command cycle itself.
                    w_mem_we    = 1'b1;
                    w_addr_next = s.s_address[MEM_AW-1:0] + 1'b1;
                    w_cnt_next  = w_cmd_cnt - 5'd1;
                    if (w_cmd_cnt != 5'd1)
                        w_state_next = ST_WR_BURST;
                end else if (w_accept && s.s_read) begin
                    w_addr_next  = s.s_address[MEM_AW-1:0];
                    w_cnt_next   = w_cmd_cnt;
                    w_state_next = ST_RD_BURST;
                end
            end
            ST_WR_BURST: begin
                if (s.s_write) begin
                    w_mem_we    = 1'b1;
                    w_addr_next = r_addr + 1'b1;
                    w_cnt_next  = r_cnt - 5'd1;
                    if (r_cnt == 5'd1)
                        w_state_next = ST_IDLE;
                end
            end
            ST_RD_BURST: begin
                w_issue     = 1'b1;
                w_addr_next = r_addr + 1'b1;
                w_cnt_next  = r_cnt - 5'd1;
                if (r_cnt == 5'd1)
                    w_state_next = ST_RD_DRAIN;
            end
            ST_RD_DRAIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        r_rst_d <= rst;
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_rdvalid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_cnt     <= w_cnt_next;
            r_rdvalid <= w_issue;
        end
    end

    // A beat presented while reset is high is dropped.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (s.s_byteenable[b])
                    r_mem[w_mem_addr][8*b +: 8] <= s.s_writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= '0;
        else if (w_issue)
            r_rdata <= r_mem[w_mem_addr];
    end
endmodule

// File: tb/tb_avalon_burst_ram_slave.sv
// Self-checking bench for avalon_burst_ram_slave: directed scenarios plus randomized
// bursts checked against an array model of the RAM and the documented read timing.
module tb_avalon_burst_ram_slave;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avalon_burst_ram_slave_if bus();

    avalon_burst_ram_slave #(.MEM_AW(AW), .INIT_FILE("")) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wd  [16];
    logic [3:0]  wbe [16];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic do_write(input logic [29:0] addr, input logic [4:0] bc, input int gap_after);
        int cnt;
        int beat;
        int a;
        bit gap_done;
        cnt = (bc == 5'd0) ? 1 : int'(bc);
        beat = 0;
        gap_done = 1'b0;
        while (beat < cnt) begin
            @(posedge clk); #1;
            if (gap_after >= 0 && beat == gap_after + 1 && !gap_done) begin
                bus.s_write = 1'b0;
                bus.s_read  = 1'($urandom);
                gap_done = 1'b1;
            end else begin
                bus.s_write        = 1'b1;
                bus.s_read         = (beat == 0) ? 1'b0 : 1'($urandom);
                bus.s_address      = (beat == 0) ? addr : 30'($urandom);
                bus.s_burstcount   = (beat == 0) ? bc : 5'(cnt - beat);
                bus.s_writedata    = wd[beat];
                bus.s_byteenable   = wbe[beat];
                a = (int'(addr[AW-1:0]) + beat) % DEPTH;
                model_mem[a] = merge(model_mem[a], wd[beat], wbe[beat]);
                if (beat == 0) begin
                    @(negedge clk);
                    n_checks++;
                    if (bus.s_waitrequest !== 1'b0) begin
                        n_fail++;
                        $display("FAIL wr_cmd_waitrequest addr=%h got=%b exp=0", addr, bus.s_waitrequest);
                    end
                end
                beat++;
            end
        end
        @(posedge clk); #1;
        bus.s_write = 1'b0;
        bus.s_read  = 1'b0;
    endtask

    // Read burst; rst_at >= 0 pulses reset for one cycle at that offset from the command.
    task automatic do_read(input logic [29:0] addr, input logic [4:0] bc, input bit hold,
                           input int rst_at);
        int cnt;
        bit exp_valid;
        logic [31:0] exp_data;
        cnt = (bc == 5'd0) ? 1 : int'(bc);
        for (int k = 0; k <= cnt + 4; k++) begin
            @(posedge clk); #1;
            rst = (k == rst_at);
            bus.s_read       = (k == 0) || (hold && k <= cnt && (rst_at < 0 || k < rst_at));
            bus.s_address    = (k == 0) ? addr : 30'($urandom);
            bus.s_burstcount = (k == 0) ? bc : 5'($urandom);
            @(negedge clk);
            exp_valid = (k >= 2) && (k <= cnt + 1) && (rst_at < 0 || k <= rst_at);
            if (k == 0) begin
                n_checks++;
                if (bus.s_waitrequest !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rd_cmd_waitrequest addr=%h got=%b exp=0", addr, bus.s_waitrequest);
                end
            end
            if (rst_at >= 0 && (k == rst_at || k == rst_at + 1 || k == rst_at + 2)) begin
                n_checks++;
                if (bus.s_waitrequest !== (k != rst_at + 2)) begin
                    n_fail++;
                    $display("FAIL rst_waitrequest k=%0d got=%b exp=%b", k, bus.s_waitrequest,
                             k != rst_at + 2);
                end
            end
            n_checks++;
            if (bus.s_readdatavalid !== exp_valid) begin
                n_fail++;
                $display("FAIL rd_valid addr=%h k=%0d got=%b exp=%b", addr, k,
                         bus.s_readdatavalid, exp_valid);
            end
            if (exp_valid) begin
                exp_data = model_mem[(int'(addr[AW-1:0]) + k - 2) % DEPTH];
                n_checks++;
                if (bus.s_readdata !== exp_data) begin
                    n_fail++;
                    $display("FAIL rd_data addr=%h beat=%0d got=%h exp=%h", addr, k - 2,
                             bus.s_readdata, exp_data);
                end
            end
        end
        bus.s_read = 1'b0;
        rst = 1'b0;
        $display("read addr=%h bc=%0d hold=%0d rst_at=%0d done", addr, bc, hold, rst_at);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.s_waitrequest !== 1'b1 || bus.s_readdatavalid !== 1'b0 || bus.s_readdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d wr=%b valid=%b data=%h exp wr=1 valid=0 data=0",
                         k, bus.s_waitrequest, bus.s_readdatavalid, bus.s_readdata);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.s_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_wait got=%b exp=1", bus.s_waitrequest);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (bus.s_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got=%b exp=0", bus.s_waitrequest);
        end
        $display("reset sequence done");
    endtask

    task automatic test_single();
        wd[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
        do_write(30'h010, 5'd1, -1);
        do_read(30'h010, 5'd1, 1'b0, -1);
    endtask

    task automatic test_line();
        for (int i = 0; i < 16; i++) begin
            wd[i] = 32'h100 + 32'(i);
            wbe[i] = 4'hF;
        end
        do_write(30'h040, 5'd16, 5);
        do_read(30'h040, 5'd16, 1'b1, -1);
    endtask

    task automatic test_byteenable();
        wd[0] = 32'hFFFFFFFF; wbe[0] = 4'hF;
        do_write(30'h020, 5'd1, -1);
        wd[0] = 32'h00000000; wbe[0] = 4'h5;
        do_write(30'h020, 5'd1, -1);
        n_checks++;
        if (model_mem[12'h020] !== 32'hFF00FF00) begin
            n_fail++;
            $display("FAIL be_model got=%h exp=ff00ff00", model_mem[12'h020]);
        end
        do_read(30'h020, 5'd1, 1'b0, -1);
    endtask

    task automatic test_wrap();
        wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002; wd[2] = 32'hCCCC0003; wd[3] = 32'hDDDD0004;
        for (int i = 0; i < 4; i++) wbe[i] = 4'hF;
        do_write(30'hFFE, 5'd4, -1);
        do_read(30'hFFE, 5'd4, 1'b1, -1);
        do_read(30'h1000, 5'd1, 1'b0, -1);
        do_read(30'h000, 5'd2, 1'b0, -1);
    endtask

    task automatic test_reset_mid_read();
        do_read(30'h040, 5'd16, 1'b1, 5);
        do_read(30'h045, 5'd1, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [29:0] a;
        logic [4:0]  bc;
        int          gap;
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                wbe[i] = 4'hF;
            end
            do_write(30'h200 + 30'(blk * 16), 5'd16, -1);
        end
        for (int t = 0; t < 24; t++) begin
            a  = {18'($urandom), 12'(12'h200 + 12'($urandom_range(0, 12'hEF)))};
            bc = 5'($urandom_range(0, 16));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wd[i] = $urandom;
                    wbe[i] = 4'($urandom);
                end
                gap = (bc > 5'd1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(bc) - 2)) : -1;
                do_write(a, bc, gap);
                $display("write addr=%h bc=%0d gap=%0d done", a, bc, gap);
            end else begin
                do_read(a, bc, 1'($urandom), -1);
            end
        end
    endtask

    initial begin
        bus.s_address = '0; bus.s_burstcount = '0; bus.s_read = 1'b0; bus.s_write = 1'b0;
        bus.s_writedata = '0; bus.s_byteenable = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        test_reset();
        test_single();
        test_line();
        test_byteenable();
        test_wrap();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
